// File: rtl/expr_seq_eval.sv
// Streaming evaluator for digit ((+|*) digit)* '=' expressions.
// Accepts ASCII characters and returns a sum of products, or an error flag.
module expr_seq_eval #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] result,
  output logic         err
);

  typedef enum logic [1:0] {
    S_DIGIT = 2'd0,
    S_OP    = 2'd1,
    S_ERR   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic PEND_ADD = 1'b0;
  localparam logic PEND_MUL = 1'b1;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  state_t         state_r, state_nx_s;
  logic [W-1:0]   acc_r, acc_nx_s;
  logic [W-1:0]   term_r, term_nx_s;
  logic           pend_r, pend_nx_s;
  logic [W-1:0]   result_r, result_nx_s;
  logic           err_r, err_nx_s;
  logic           res_valid_r, res_valid_nx_s;
  logic           accept_s;
  logic [7:0]     digit_raw_s;
  logic [W-1:0]   digit_s;

  assign in_ready    = (state_r != S_OUT);
  assign accept_s    = in_valid && in_ready;
  assign digit_raw_s = in - 8'h30;
  assign digit_s     = {{(W-4){1'b0}}, digit_raw_s[3:0]};
  assign res_valid   = res_valid_r;
  assign result      = result_r;
  assign err         = err_r;

  // Next-state and datapath update for the parser/result controller
  always_comb begin
    state_nx_s     = state_r;
    acc_nx_s       = acc_r;
    term_nx_s      = term_r;
    pend_nx_s      = pend_r;
    result_nx_s    = result_r;
    err_nx_s       = err_r;
    res_valid_nx_s = res_valid_r;
    case (state_r)
      S_DIGIT: begin
        if (!accept_s) begin
          state_nx_s = state_r;
        end else if (is_digit(in)) begin
          term_nx_s  = (pend_r == PEND_MUL) ? term_r * digit_s : digit_s;
          state_nx_s = S_OP;
        end else if (in == 8'h3D) begin
          err_nx_s       = 1'b1;
          result_nx_s    = {W{1'b0}};
          res_valid_nx_s = 1'b1;
          state_nx_s     = S_OUT;
        end else begin
          state_nx_s = S_ERR;
        end
      end
      S_OP: begin
        if (!accept_s) begin
          state_nx_s = state_r;
        end else if (in == 8'h2B) begin
          acc_nx_s   = acc_r + term_r;
          pend_nx_s  = PEND_ADD;
          state_nx_s = S_DIGIT;
        end else if (in == 8'h2A) begin
          pend_nx_s  = PEND_MUL;
          state_nx_s = S_DIGIT;
        end else if (in == 8'h3D) begin
          result_nx_s    = acc_r + term_r;
          err_nx_s       = 1'b0;
          res_valid_nx_s = 1'b1;
          state_nx_s     = S_OUT;
        end else begin
          state_nx_s = S_ERR;
        end
      end
      S_ERR: begin
        if (accept_s && (in == 8'h3D)) begin
          err_nx_s       = 1'b1;
          result_nx_s    = {W{1'b0}};
          res_valid_nx_s = 1'b1;
          state_nx_s     = S_OUT;
        end else begin
          state_nx_s = S_ERR;
        end
      end
      S_OUT: begin
        // Expression context is cleared only once the consumer takes the result
        if (res_ready) begin
          res_valid_nx_s = 1'b0;
          acc_nx_s       = {W{1'b0}};
          term_nx_s      = {W{1'b0}};
          pend_nx_s      = PEND_ADD;
          state_nx_s     = S_DIGIT;
        end else begin
          res_valid_nx_s = 1'b1;
        end
      end
      default: begin
        state_nx_s = S_DIGIT;
      end
    endcase
  end

  // State and datapath registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r     <= S_DIGIT;
      acc_r       <= {W{1'b0}};
      term_r      <= {W{1'b0}};
      pend_r      <= PEND_ADD;
      result_r    <= {W{1'b0}};
      err_r       <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      acc_r       <= acc_nx_s;
      term_r      <= term_nx_s;
      pend_r      <= pend_nx_s;
      result_r    <= result_nx_s;
      err_r       <= err_nx_s;
      res_valid_r <= res_valid_nx_s;
    end
  end

endmodule
